// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the FFT datapath.
// Quadrant codes and quarter-wave cosine table generation.
package fft_pkg;

  localparam int DATA_WIDTH_DEF = 18;
  localparam int LOG2_N_DEF     = 3;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam longint PI_Q30 = 64'd3373259426;

  function automatic int tbl_depth(input int log2n);
    return (1 << (log2n - 2)) + 1;
  endfunction

  // round(cos(2*pi*i/N) * (2^mag_w - 1)), Taylor series in Q30
  function automatic longint qcos(
    input int i,
    input int log2n,
    input int mag_w
  );
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint fs;
    longint r;
    x    = (PI_Q30 * longint'(i)) / (longint'(1) << (log2n - 1));
    x2   = (x * x) >>> 30;
    term = longint'(1) << 30;
    acc  = term;
    for (int n = 1; n < 16; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n)));
      acc  = acc + term;
    end
    fs = (longint'(1) << mag_w) - 1;
    r  = (acc * fs + (longint'(1) << 29)) >>> 30;
    if (r < 0) r = 0;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: quarter-wave cosine table, two synchronous read ports.
// Contents are elaborated from the table generator; no reset on storage.
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int ADDR_WIDTH = 2,
  parameter     INIT_FILE  = "twiddle_q_init.txt"
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int ROWS  = 1 << ADDR_WIDTH;
  localparam int DEPTH = tbl_depth(ADDR_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rom [ROWS];

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    localparam int IDX = (g < DEPTH) ? g : 0;
    localparam logic [DATA_WIDTH-1:0] V =
      (g < DEPTH) ? DATA_WIDTH'(qcos(IDX, ADDR_WIDTH + 1, DATA_WIDTH)) : '0;
    assign rom[g] = V;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      q_a <= rom[addr_a];
      q_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: FFT twiddle W_N^k = cos - j*sin from a quarter-wave table,
// 3-stage valid/ready pipeline with optional conjugate for the IFFT.
module twiddle_gen
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LOG2_N     = LOG2_N_DEF,
  parameter     INIT_FILE  = "twiddle_q_init.txt"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG2_N-1:0]     k,
  input  logic                  inverse,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] w_re,
  output logic [DATA_WIDTH-1:0] w_im,
  output logic [LOG2_N-1:0]     k_out
);

  localparam int AW = LOG2_N - 1;
  localparam int MW = DATA_WIDTH - 1;
  localparam logic [AW-1:0] QUARTER = AW'(1 << (LOG2_N - 2));

  logic          advance;
  logic [AW-1:0] r;

  logic              s1_valid_q;
  quad_e             s1_quad_q;
  logic [AW-1:0]     s1_a_q;
  logic [AW-1:0]     s1_b_q;
  logic              s1_inv_q;
  logic [LOG2_N-1:0] s1_k_q;

  logic              s2_valid_q;
  quad_e             s2_quad_q;
  logic              s2_inv_q;
  logic [LOG2_N-1:0] s2_k_q;
  logic [MW-1:0]     rom_a;
  logic [MW-1:0]     rom_b;

  logic signed [DATA_WIDTH-1:0] ca;
  logic signed [DATA_WIDTH-1:0] cb;
  logic signed [DATA_WIDTH-1:0] re_d;
  logic signed [DATA_WIDTH-1:0] im_m;
  logic signed [DATA_WIDTH-1:0] im_d;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] w_re_q;
  logic [DATA_WIDTH-1:0] w_im_q;
  logic [LOG2_N-1:0]     k_out_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  if (LOG2_N > 2) begin : g_r
    assign r = AW'(k[LOG2_N-3:0]);
  end else begin : g_r0
    assign r = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_quad_q  <= Q0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_inv_q   <= 1'b0;
      s1_k_q     <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_quad_q  <= quad_e'(k[LOG2_N-1:LOG2_N-2]);
      s1_a_q     <= r;
      s1_b_q     <= QUARTER - r;
      s1_inv_q   <= inverse;
      s1_k_q     <= k;
    end
  end

  twiddle_qrom #(
    .DATA_WIDTH (MW),
    .ADDR_WIDTH (AW),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .en     (advance),
    .addr_a (s1_a_q),
    .addr_b (s1_b_q),
    .q_a    (rom_a),
    .q_b    (rom_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_quad_q  <= Q0;
      s2_inv_q   <= 1'b0;
      s2_k_q     <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_quad_q  <= s1_quad_q;
      s2_inv_q   <= s1_inv_q;
      s2_k_q     <= s1_k_q;
    end
  end

  assign ca = $signed({1'b0, rom_a});
  assign cb = $signed({1'b0, rom_b});

  // Magnitudes never reach -2^(W-1), so negation cannot overflow
  always_comb begin
    re_d = '0;
    im_m = '0;
    unique case (s2_quad_q)
      Q0: begin re_d = ca;  im_m = -cb; end
      Q1: begin re_d = -cb; im_m = -ca; end
      Q2: begin re_d = -ca; im_m = cb;  end
      Q3: begin re_d = cb;  im_m = ca;  end
      default: ;
    endcase
    im_d = s2_inv_q ? -im_m : im_m;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      w_re_q      <= '0;
      w_im_q      <= '0;
      k_out_q     <= '0;
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        w_re_q  <= re_d;
        w_im_q  <= im_d;
        k_out_q <= s2_k_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign w_re      = w_re_q;
  assign w_im      = w_im_q;
  assign k_out     = k_out_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: vector table, streaming scoreboard and N=64 sweep
// against a real-valued exp(-j*2*pi*k/N) model.
module tb_twiddle_gen;

  localparam int  DW = 18;
  localparam real PI = 3.14159265358979323846;
  localparam real FS = 131071.0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid, in_ready, inverse, out_valid, out_ready;
  logic [2:0]           k, k_out;
  logic signed [DW-1:0] w_re, w_im;

  logic                 in_valid6, in_ready6, inverse6, out_valid6, out_ready6;
  logic [5:0]           k6, k_out6;
  logic signed [DW-1:0] w_re6, w_im6;

  twiddle_gen #(.DATA_WIDTH(DW), .LOG2_N(3)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .k(k), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready),
    .w_re(w_re), .w_im(w_im), .k_out(k_out)
  );

  twiddle_gen #(.DATA_WIDTH(DW), .LOG2_N(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(in_ready6),
    .k(k6), .inverse(inverse6),
    .out_valid(out_valid6), .out_ready(out_ready6),
    .w_re(w_re6), .w_im(w_im6), .k_out(k_out6)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act,
                         input longint exp, input longint tol);
    tests++;
    if (act - exp > tol || exp - act > tol) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_re(input int kk, input int n);
    return rnd($cos(2.0 * PI * kk / n) * FS);
  endfunction

  function automatic int ref_im(input int kk, input bit inv, input int n);
    real s;
    s = -$sin(2.0 * PI * kk / n);
    if (inv) s = -s;
    return rnd(s * FS);
  endfunction

  function automatic int sgn(input longint v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  typedef struct {
    int k;
    bit inv;
    int cyc;
  } req_t;

  req_t exp_q[$];
  int   cyc_n = 0;
  int   pop_n = 0;
  bit   chk_lat = 1'b0;
  bit   hold_v = 1'b0;
  int   hold_re, hold_im, hold_k;

  task automatic cyc(input bit v, input int kk, input bit inv,
                     input bit ordy, output bit acc);
    req_t rq;
    in_valid  = v;
    k         = kk[2:0];
    inverse   = inv;
    out_ready = ordy;
    #1;
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_re", w_re, hold_re);
      chk("hold_im", w_im, hold_im);
      chk("hold_k", k_out, hold_k);
    end
    hold_v  = out_valid && !out_ready;
    hold_re = w_re;
    hold_im = w_im;
    hold_k  = k_out;
    if (out_valid && out_ready) begin
      pop_n++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        rq = exp_q.pop_front();
        chk("stream_k", k_out, rq.k);
        chk("stream_re", w_re, ref_re(rq.k, 8));
        chk("stream_im", w_im, ref_im(rq.k, rq.inv, 8));
        if (chk_lat) chk("stream_lat", cyc_n - rq.cyc, 3);
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back('{kk, inv, cyc_n});
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain();
    bit a;
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      cyc(1'b0, 0, 1'b0, 1'b1, a);
      g++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic one_shot(input int kk, input bit inv, output int lat);
    in_valid  = 1'b1;
    k         = kk[2:0];
    inverse   = inv;
    out_ready = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    int k;
    bit inv;
    int re;
    int im;
  } vec_t;

  vec_t vt[10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit a;
    bit v, ordy, inv_p;
    int lat, nk, g;

    vt[0] = '{0, 1'b0, 131071, 0};
    vt[1] = '{1, 1'b0, 92681, -92681};
    vt[2] = '{2, 1'b0, 0, -131071};
    vt[3] = '{3, 1'b0, -92681, -92681};
    vt[4] = '{4, 1'b0, -131071, 0};
    vt[5] = '{5, 1'b0, -92681, 92681};
    vt[6] = '{6, 1'b0, 0, 131071};
    vt[7] = '{7, 1'b0, 92681, 92681};
    vt[8] = '{1, 1'b1, 92681, 92681};
    vt[9] = '{6, 1'b1, 0, -131071};

    in_valid = 0; k = 0; inverse = 0; out_ready = 1;
    in_valid6 = 0; k6 = 0; inverse6 = 0; out_ready6 = 1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_w_re", w_re, 0);
    chk("rst_w_im", w_im, 0);
    chk("rst_k_out", k_out, 0);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      one_shot(vt[i].k, vt[i].inv, lat);
      chk("vec_lat", lat, 3);
      chk("vec_re", w_re, vt[i].re);
      chk("vec_im", w_im, vt[i].im);
      chk("vec_k", k_out, vt[i].k);
      @(negedge clk);
    end

    chk_lat = 1'b1;
    cyc(1'b1, 1, 1'b0, 1'b1, a);
    cyc(1'b1, 2, 1'b0, 1'b1, a);
    cyc(1'b1, 5, 1'b0, 1'b1, a);
    cyc(1'b1, 7, 1'b0, 1'b1, a);
    drain();

    chk_lat = 1'b0;
    pop_n = 0;
    nk = 0;
    g = 0;
    inv_p = 1'(($urandom() >> 3) & 1);
    while ((nk < 8 || exp_q.size() > 0) && g < 400) begin
      v    = (nk < 8) && ($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 1));
      cyc(v, nk, inv_p, ordy, a);
      if (a) begin
        nk++;
        inv_p = 1'($urandom_range(0, 1));
      end
      g++;
    end
    chk("stall_stream_done", (g < 400) ? 1 : 0, 1);
    chk("stall_stream_count", pop_n, 8);

    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), a);
    end
    drain();

    chk_lat = 1'b1;
    cyc(1'b1, 3, 1'b0, 1'b1, a);
    cyc(1'b1, 4, 1'b1, 1'b1, a);
    cyc(1'b1, 6, 1'b0, 1'b1, a);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("prerst_valid", out_valid, 1);
    chk("prerst_k", k_out, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_w_re", w_re, 0);
    chk("midrst_w_im", w_im, 0);
    chk("midrst_k_out", k_out, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("postrst_idle", out_valid, 0);
      cyc(1'b0, 0, 1'b0, 1'b1, a);
    end
    cyc(1'b1, 2, 1'b1, 1'b1, a);
    drain();

    for (int kk = 0; kk < 64; kk++) begin
      for (int iv = 0; iv < 2; iv++) begin
        in_valid6 = 1'b1;
        k6        = kk[5:0];
        inverse6  = iv[0];
        #1;
        chk("n64_in_ready", in_ready6, 1);
        @(negedge clk);
        in_valid6 = 1'b0;
        lat = 1;
        while (!out_valid6 && lat < 8) begin
          @(negedge clk);
          lat++;
        end
        chk("n64_lat", lat, 3);
        chk("n64_k", k_out6, kk);
        chk_tol("n64_re", w_re6, ref_re(kk, 64), 1);
        chk_tol("n64_im", w_im6, ref_im(kk, iv[0], 64), 1);
        chk("n64_sign_re", sgn(w_re6), sgn(ref_re(kk, 64)));
        chk("n64_sign_im", sgn(w_im6), sgn(ref_im(kk, iv[0], 64)));
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
